mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage: sits between the EXE->MEM register and the MEM->WB register and drives the MEM->WB register inputs.
//  Performs loads/stores to a variable-latency data memory over a req/ack handshake.
//  Raises freeze to stall upstream stages until the access completes.
//  Non-memory instructions pass through combinationally with no stall.
// PARAMETERS
//  MEM_BASE      32'd1024  byte address of data-memory word 0
//  DMEM_WORDS    64        number of 32-bit words; word index must be < DMEM_WORDS
//  TIMEOUT_CYC   16        ACCESS cycles without mem_ack before abort (>=1)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  WB_en_in         in   1   EXE->MEM: writeback enable
//  MEM_R_EN_in      in   1   EXE->MEM: load
//  MEM_W_EN_in      in   1   EXE->MEM: store (never together with MEM_R_EN_in)
//  ALU_result_in    in   32  EXE->MEM: effective byte address / ALU result
//  ST_val_in        in   32  EXE->MEM: store data
//  Dest_in          in   5   EXE->MEM: destination register
//  PC_in            in   32  EXE->MEM: PC of the instruction
//  mem_req          out  1   registered; access request held until ack
//  mem_we           out  1   registered; 1=write, 0=read
//  mem_addr         out  32  registered word index (ALU_result_in-MEM_BASE)>>2
//  mem_wdata        out  32  registered store data
//  mem_ack          in   1   one-cycle completion strobe; mem_rdata valid with it
//  mem_rdata        in   32  read data
//  WB_en            out  1   to MEM->WB register
//  MEM_R_EN         out  1   to MEM->WB register
//  ALU_result       out  32  to MEM->WB register (pass-through)
//  Mem_read_value   out  32  to MEM->WB register
//  Dest             out  5   to MEM->WB register (pass-through)
//  PC               out  32  to MEM->WB register (pass-through)
//  freeze           out  1   combinational stall to PC/IF/ID/EXE registers and MEM->WB register
//  mem_err          out  1   registered one-cycle pulse: misaligned, out-of-range or timeout
// BEHAVIOUR
//  Reset: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_q=0, mem_err=0, tmo_cnt=0.
//  acc = MEM_R_EN_in|MEM_W_EN_in; bad = acc & (ALU_result_in[1:0]!=0 | index>=DMEM_WORDS | ALU_result_in<MEM_BASE).
//  IDLE: acc&!bad -> freeze=1; on the edge, latch mem_addr/mem_we/mem_wdata, set mem_req=1 -> ACCESS.
//        bad -> no bus access, no stall, WB_en=0, mem_err pulses the next cycle, stay in IDLE.
//        !acc -> freeze=0, stay in IDLE.
//  ACCESS: freeze=1; tmo_cnt++ each cycle.
//        mem_ack=1 -> rdata_q<=mem_rdata (loads only), mem_req<=0, ->DONE.
//        tmo_cnt==TIMEOUT_CYC-1 without ack -> mem_req<=0, rdata_q<=0, mem_err pulse, timeout flag set, ->DONE.
//  DONE: freeze=0; outputs valid and MEM->WB latches them at the end of this cycle; ->IDLE unconditionally (no re-issue).
//  Outputs: Mem_read_value=rdata_q in DONE, else 0. WB_en=WB_en_in & !bad & !(timeout flag, load).
//        Other outputs are combinational pass-through of the *_in signals.
//  Latency: ack at the earliest cycle (N+1 after request in cycle N) -> freeze high for N and N+1, DONE at N+2 (2 stall cycles).
//  Store: MEM_R_EN=0; WB_en passes through (0 from decode).
//  mem_ack in IDLE/DONE (late ack after abort or reset) is ignored.
//  Reset while in ACCESS: IDLE next cycle, mem_req=0, freeze=0; the pending instruction is discarded.
//  tmo_cnt clears on entry to ACCESS; its width is clog2(TIMEOUT_CYC)+1.
// STRUCTURE
//  mips_pkg: state enum {IDLE,ACCESS,DONE}, MEM_BASE default, REG_ADDR_W=5, WORD_W=32.
//  Sub-module dmem_addr_check (combinational): computes the word index and bad (alignment + range).
//  FSM, timeout counter and registered bus outputs live in mem_access_stage.
// TESTING
//  ALU op (no mem), Dest=5'd3 -> freeze=0 for every cycle; outputs equal inputs the same cycle; mem_req never rises.
//  LW addr 1028, ack 1 cycle after req, rdata=32'hDEADBEEF -> mem_addr=1; freeze high 2 cycles; DONE: Mem_read_value=DEADBEEF, WB_en=1.
//  SW addr 1032, ST_val=32'h12345678, ack after 5 cycles -> mem_we=1, mem_addr=2, wdata held stable; freeze high 6 cycles.
//  LW addr 1030 (misaligned) or 1024+4*64 (out of range) -> no mem_req; mem_err 1-cycle pulse; WB_en=0; freeze=0.
//  LW with no ack, TIMEOUT_CYC=16 -> mem_req drops after 16 ACCESS cycles; mem_err pulse; DONE: WB_en=0, Mem_read_value=0.
//  rst in the 3rd ACCESS cycle, then ack 2 cycles later -> IDLE; mem_req=0 and freeze=0 next cycle; late ack ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage: FSM states, bus widths
// and the byte-address to word-index helper.
package mem_access_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [WORD_W-1:0] MEM_BASE_DEF = 32'd1024;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr,
                                                     input logic [WORD_W-1:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request bus: request/write/address/data out, one-cycle ack strobe back.
// master = MEM stage, slave = data memory.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_access_stage_dmem_addr_check.sv
// Combinational word-index computation and alignment/range check for data-memory accesses.
// Zero latency, no backpressure.
module mem_access_stage_dmem_addr_check
    import mem_access_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] MEM_BASE   = MEM_BASE_DEF,
    parameter int                DMEM_WORDS = 64
) (
    input  logic              acc,
    input  logic [WORD_W-1:0] byte_addr,
    output logic [WORD_W-1:0] word_idx,
    output logic              bad
);

    assign word_idx = word_index(byte_addr, MEM_BASE);

    // Below-base addresses wrap to a huge index, but are rejected explicitly anyway.
    assign bad = acc & ((byte_addr[1:0] != 2'b00)
                      | (word_idx >= WORD_W'(DMEM_WORDS))
                      | (byte_addr < MEM_BASE));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the data-memory bus and freezes upstream until done.
// Non-memory ops pass through in 0 cycles; an access stalls 1 + (cycles to ack) cycles.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] MEM_BASE    = MEM_BASE_DEF,
    parameter int                DMEM_WORDS  = 64,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_en_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic [WORD_W-1:0]     ALU_result_in,
    input  logic [WORD_W-1:0]     ST_val_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    input  logic [WORD_W-1:0]     PC_in,
    mem_access_stage_if.master    mem,
    output logic                  WB_en,
    output logic                  MEM_R_EN,
    output logic [WORD_W-1:0]     ALU_result,
    output logic [WORD_W-1:0]     Mem_read_value,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic [WORD_W-1:0]     PC,
    output logic                  freeze,
    output logic                  mem_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              acc, bad, tmo_hit;
    logic [WORD_W-1:0] word_idx;
    logic              req_q, we_q, err_q, tmo_flag_q;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
    logic [TMO_W-1:0]  tmo_cnt_q;

    assign acc = MEM_R_EN_in | MEM_W_EN_in;

    mem_access_stage_dmem_addr_check #(
        .MEM_BASE   (MEM_BASE),
        .DMEM_WORDS (DMEM_WORDS)
    ) u_addr_check (
        .acc       (acc),
        .byte_addr (ALU_result_in),
        .word_idx  (word_idx),
        .bad       (bad)
    );

    // An ack in the final allowed cycle still counts as a completion.
    assign tmo_hit = (state_q == ACCESS) & ~mem.mem_ack & (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc & ~bad) begin
                    freeze  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                freeze = 1'b1;
                if (mem.mem_ack | tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            err_q <= ((state_q == IDLE) & bad) | tmo_hit;
            case (state_q)
                IDLE: begin
                    if (acc & ~bad) begin
                        req_q      <= 1'b1;
                        we_q       <= MEM_W_EN_in;
                        addr_q     <= word_idx;
                        wdata_q    <= ST_val_in;
                        tmo_cnt_q  <= '0;
                        tmo_flag_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (~we_q) begin
                            rdata_q <= mem.mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        req_q      <= 1'b0;
                        rdata_q    <= '0;
                        tmo_flag_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem_err       = err_q;

    // A timed-out load must not write back a fabricated zero.
    assign WB_en          = WB_en_in & ~bad & ~((state_q == DONE) & tmo_flag_q & MEM_R_EN_in);
    assign MEM_R_EN       = MEM_R_EN_in;
    assign ALU_result     = ALU_result_in;
    assign Mem_read_value = (state_q == DONE) ? rdata_q : '0;
    assign Dest           = Dest_in;
    assign PC             = PC_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a responding data-memory model.
module tb_mem_access_stage;

    localparam int          TIMEOUT_CYC = 16;
    localparam logic [31:0] BASE        = 32'd1024;
    localparam logic [31:0] LIMIT       = 32'd1024 + 32'd4 * 32'd64;

    typedef struct {
        logic        wb;
        logic        rd;
        logic [31:0] alu;
        logic [31:0] mrv;
        logic [4:0]  dest;
        logic [31:0] pc;
        int          stall;
        bit          tmo;
        bit          bad;
    } exp_t;

    typedef struct {
        int          k;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_item_t;

    logic        clk;
    logic        rst;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, ST_val_in, PC_in;
    logic [4:0]  Dest_in;
    logic        WB_en, MEM_R_EN, freeze, mem_err;
    logic [31:0] ALU_result, Mem_read_value, PC;
    logic [4:0]  Dest;

    mem_access_stage_if mif();

    mem_access_stage #(
        .MEM_BASE    (32'd1024),
        .DMEM_WORDS  (64),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_en_in       (WB_en_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val_in      (ST_val_in),
        .Dest_in        (Dest_in),
        .PC_in          (PC_in),
        .mem            (mif),
        .WB_en          (WB_en),
        .MEM_R_EN       (MEM_R_EN),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Dest           (Dest),
        .PC             (PC),
        .freeze         (freeze),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        eq[$];
    mem_item_t   mq[$];
    bit          mon_en   = 0;
    bit          resp_en  = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected result of one instruction from the architectural rules.
    task automatic issue(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] stv,
                         input logic [31:0] pc, input logic [4:0] dest,
                         input int k, input logic [31:0] rdata);
        exp_t      e;
        mem_item_t m;
        bit        acc, bad, got;
        acc = rd | wr;
        bad = acc && ((addr % 4) != 0 || addr < BASE || addr >= LIMIT);
        e.rd = rd; e.alu = addr; e.dest = dest; e.pc = pc;
        e.tmo = 0; e.bad = bad; e.mrv = '0; e.stall = 0; e.wb = wb;
        if (bad) begin
            e.wb = 1'b0;
        end else if (acc) begin
            m.k = k; m.we = wr; m.addr = (addr - BASE) / 4; m.wdata = stv; m.rdata = rdata;
            mq.push_back(m);
            if (k == 0) begin
                e.tmo = 1; e.stall = TIMEOUT_CYC + 1; last_rdata = '0;
                if (rd) e.wb = 1'b0;
            end else begin
                e.stall = k + 1;
                if (rd) last_rdata = rdata;
                e.mrv = last_rdata;
            end
        end
        eq.push_back(e);
        WB_en_in = wb; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
        ALU_result_in = addr; ST_val_in = stv; PC_in = pc; Dest_in = dest;
        mon_en = 1;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (freeze === 1'b0) got = 1;
        end
        if (!got) chk("issue_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every freeze-low cycle presents one instruction to the MEM->WB register.
    int   stall_cnt = 0;
    bit   err_next  = 0;
    bit   out_now, tmo_now, bad_now;
    exp_t ce;
    always @(negedge clk) begin
        if (mon_en) begin
            out_now = (freeze === 1'b0);
            tmo_now = 0;
            bad_now = 0;
            if (out_now) begin
                if (eq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    ce = eq.pop_front();
                    chk("WB_en", {31'd0, WB_en}, {31'd0, ce.wb});
                    chk("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, ce.rd});
                    chk("ALU_result", ALU_result, ce.alu);
                    chk("Mem_read_value", Mem_read_value, ce.mrv);
                    chk("Dest", {27'd0, Dest}, {27'd0, ce.dest});
                    chk("PC", PC, ce.pc);
                    chk("stall_cycles", stall_cnt, ce.stall);
                    tmo_now = ce.tmo;
                    bad_now = ce.bad;
                end
                stall_cnt = 0;
            end else begin
                stall_cnt++;
            end
            chk("mem_err", {31'd0, mem_err}, {31'd0, err_next | tmo_now});
            err_next = out_now & bad_now;
        end
    end

    // Data-memory model: answers each request after the planned number of ACCESS cycles.
    mem_item_t cm;
    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && mif.mem_req === 1'b1) begin
                if (mq.size() == 0) begin
                    chk("spurious_req", 32'd1, 32'd0);
                end else begin
                    bit done;
                    cm = mq.pop_front();
                    chk("mem_we", {31'd0, mif.mem_we}, {31'd0, cm.we});
                    done = 0;
                    for (int j = 1; j <= TIMEOUT_CYC + 1 && !done; j++) begin
                        chk("req_held", {31'd0, mif.mem_req}, 32'd1);
                        chk("mem_addr", mif.mem_addr, cm.addr);
                        chk("mem_wdata", mif.mem_wdata, cm.wdata);
                        if (j == cm.k) begin
                            mif.mem_ack   = 1'b1;
                            mif.mem_rdata = cm.rdata;
                        end
                        @(negedge clk);
                        if (mif.mem_ack) begin
                            mif.mem_ack   = 1'b0;
                            mif.mem_rdata = $urandom;
                            done = 1;
                        end else if (j == TIMEOUT_CYC) begin
                            done = 1;
                        end
                        if (done) chk("req_drop", {31'd0, mif.mem_req}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          kind, k;
        bit          st;
        rst = 1'b1;
        WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_result_in = '0; ST_val_in = '0; PC_in = '0; Dest_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_mrv", Mem_read_value, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_en = 1;

        issue(1, 0, 0, 32'h0000_0abc, 32'h0, 32'h100, 5'd3, 0, 32'h0);
        issue(1, 1, 0, 32'd1028, 32'h0, 32'h104, 5'd7, 1, 32'hDEADBEEF);
        issue(0, 0, 1, 32'd1032, 32'h12345678, 32'h108, 5'd0, 5, 32'h0);
        issue(1, 1, 0, 32'd1030, 32'h0, 32'h10c, 5'd8, 1, 32'h0);
        issue(1, 1, 0, LIMIT, 32'h0, 32'h110, 5'd9, 1, 32'h0);
        issue(1, 1, 0, 32'd1100, 32'h0, 32'h114, 5'd10, 0, 32'h0);
        issue(0, 0, 1, 32'd1104, 32'h55aa55aa, 32'h118, 5'd0, 2, 32'h0);
        issue(1, 0, 0, 32'd1020, 32'h0, 32'h11c, 5'd11, 0, 32'h0);

        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 9);
            k    = $urandom_range(1, 8);
            st   = $urandom_range(0, 1);
            a    = BASE + 32'd4 * 32'($urandom_range(0, 63));
            case (kind)
                0, 1: issue($urandom_range(0, 1), 0, 0, $urandom, $urandom, $urandom,
                            5'($urandom), 0, 32'h0);
                2, 3, 4: issue($urandom_range(0, 1), 1, 0, a, $urandom, $urandom,
                               5'($urandom), k, $urandom);
                5, 6: issue($urandom_range(0, 1), 0, 1, a, $urandom, $urandom,
                            5'($urandom), k, $urandom);
                7: issue(1, !st, st, a + 32'($urandom_range(1, 3)), $urandom, $urandom,
                         5'($urandom), k, 32'h0);
                8: issue(1, !st, st, st ? LIMIT + 32'd4 * 32'($urandom_range(0, 100))
                                        : BASE - 32'd4 * 32'($urandom_range(1, 100)),
                         $urandom, $urandom, 5'($urandom), k, 32'h0);
                default: issue($urandom_range(0, 1), !st, st, a, $urandom, $urandom,
                               5'($urandom), 0, $urandom);
            endcase
        end
        issue(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        mon_en  = 0;
        resp_en = 0;
        chk("sb_empty", eq.size(), 32'd0);
        chk("mq_empty", mq.size(), 32'd0);

        // Reset during the 3rd ACCESS cycle, then a stale ack two cycles later.
        WB_en_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; ALU_result_in = 32'd1040;
        begin
            bit seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (mif.mem_req === 1'b1) seen = 1;
            end
            chk("rst_test_req_seen", {31'd0, seen}, 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        MEM_R_EN_in = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_access_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_access_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_access_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("late_ack_req", {31'd0, mif.mem_req}, 32'd0);
            chk("late_ack_freeze", {31'd0, freeze}, 32'd0);
            chk("late_ack_mrv", Mem_read_value, 32'd0);
            chk("late_ack_err", {31'd0, mem_err}, 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
